// File: rtl/reg_file.sv
// Parametrised register file: DEPTH x D bits, one write port, two registered read ports, synchronous clear.
// Define REG_FILE_BYPASS_EN for write-first forwarding; the default build reads the pre-edge contents.
module reg_file #(
    parameter int A     = 8,
    parameter int D     = 8,
    parameter int DEPTH = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         we,
    input  logic [A-1:0] waddr,
    input  logic [D-1:0] wdata,
    input  logic         re0,
    input  logic [A-1:0] raddr0,
    output logic [D-1:0] rdata0,
    input  logic         re1,
    input  logic [A-1:0] raddr1,
    output logic [D-1:0] rdata1
);

    localparam int         IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [A:0] LIMIT = (A+1)'(DEPTH);

    logic [D-1:0] mem [DEPTH];
    logic         wr_hit;
    logic         rd_ok0;
    logic         rd_ok1;
    logic [D-1:0] rd_next0;
    logic [D-1:0] rd_next1;

    // Addresses at or beyond DEPTH have no backing entry: writes are dropped, reads return zero.
    assign wr_hit = we && ({1'b0, waddr} < LIMIT);
    assign rd_ok0 = {1'b0, raddr0} < LIMIT;
    assign rd_ok1 = {1'b0, raddr1} < LIMIT;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_hit) begin
            mem[waddr[IW-1:0]] <= wdata;
        end
    end

    always_comb begin
        rd_next0 = '0;
        if (rd_ok0) begin
`ifdef REG_FILE_BYPASS_EN
            if (clr) begin
                rd_next0 = '0;
            end else if (wr_hit && (waddr == raddr0)) begin
                rd_next0 = wdata;
            end else begin
                rd_next0 = mem[raddr0[IW-1:0]];
            end
`else
            rd_next0 = mem[raddr0[IW-1:0]];
`endif
        end
    end

    always_comb begin
        rd_next1 = '0;
        if (rd_ok1) begin
`ifdef REG_FILE_BYPASS_EN
            if (clr) begin
                rd_next1 = '0;
            end else if (wr_hit && (waddr == raddr1)) begin
                rd_next1 = wdata;
            end else begin
                rd_next1 = mem[raddr1[IW-1:0]];
            end
`else
            rd_next1 = mem[raddr1[IW-1:0]];
`endif
        end
    end

    // Read data only moves on an enabled read, so it holds across idle cycles and clears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            if (re0) begin
                rdata0 <= rd_next0;
            end
            if (re1) begin
                rdata1 <= rd_next1;
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file (DEPTH=200) against an array-based reference model.
// Tracks REG_FILE_BYPASS_EN so the expected collision behaviour matches the build.
module tb_reg_file;

    localparam int A     = 8;
    localparam int D     = 8;
    localparam int DEPTH = 200;

    logic         clk;
    logic         reset;
    logic         clr;
    logic         we;
    logic [A-1:0] waddr;
    logic [D-1:0] wdata;
    logic         re0;
    logic [A-1:0] raddr0;
    logic [D-1:0] rdata0;
    logic         re1;
    logic [A-1:0] raddr1;
    logic [D-1:0] rdata1;

    int errors = 0;
    int checks = 0;

    logic [D-1:0] model [256];
    logic [D-1:0] exp0;
    logic [D-1:0] exp1;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    reg_file #(.A(A), .D(D), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re0    (re0),
        .raddr0 (raddr0),
        .rdata0 (rdata0),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // What a read of address ra returns at an edge, given that edge's write/clear activity.
    function automatic logic [D-1:0] model_read(input int ra, input bit c, input bit w,
                                                input int wa, input logic [D-1:0] wd);
        if (ra >= DEPTH) return '0;
        if (BYPASS && c) return '0;
        if (BYPASS && w && wa == ra) return wd;
        return model[ra];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model[i] = '0;
    endtask

    // Drive one cycle of inputs on the falling edge, then advance the model past the rising edge.
    task automatic step(input bit w, input int wa, input int wd, input bit r0, input int ra0,
                        input bit r1, input int ra1, input bit c);
        @(negedge clk);
        we = w;
        waddr = A'(wa);
        wdata = D'(wd);
        re0 = r0;
        raddr0 = A'(ra0);
        re1 = r1;
        raddr1 = A'(ra1);
        clr = c;
        @(posedge clk);
        if (r0) exp0 = model_read(ra0, c, w, wa, D'(wd));
        if (r1) exp1 = model_read(ra1, c, w, wa, D'(wd));
        if (c) model_clear();
        else if (w && wa < DEPTH) model[wa] = D'(wd);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        checks++;
        if (rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_initial: rdata0=%h rdata1=%h expected 00 00", rdata0, rdata1);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step(1, i, 8'hA5, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 3, 1, 0, 0);
        checks++;
        if (rdata0 !== 8'hA5 || rdata1 !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL reset_prewrite: rdata0=%h rdata1=%h expected a5 a5", rdata0, rdata1);
        end
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        exp0 = '0;
        exp1 = '0;
        checks++;
        if (rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_async: rdata0=%h rdata1=%h expected 00 00", rdata0, rdata1);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i += 2) begin
            step(0, 0, 0, 1, i, 1, i + 1, 0);
            checks++;
            if (rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_readback: addr %0d rdata0=%h rdata1=%h expected 00 00",
                         i, rdata0, rdata1);
            end
        end
        for (int i = 0; i < 4; i++) step(1, i, 8'hA5, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i += 2) begin
            step(0, 0, 0, 1, i, 1, i + 1, 0);
            checks++;
            if (rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
                errors++;
                $display("[TB] FAIL clear_readback: addr %0d rdata0=%h rdata1=%h expected 00 00",
                         i, rdata0, rdata1);
            end
        end
    endtask

    task automatic test_basic();
        step(1, 8'h10, 8'h3C, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 8'h10, 0, 0, 0);
        checks++;
        if (rdata0 !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL basic_read: rdata0=%h expected 3c", rdata0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, i + 20, 8'h40 + i, 0, i + 20, 0, 0, 0);
            checks++;
            if (rdata0 !== 8'h3C) begin
                errors++;
                $display("[TB] FAIL basic_hold: cycle %0d rdata0=%h expected 3c", i, rdata0);
            end
        end
    endtask

    task automatic test_dual_port();
        step(1, 5, 8'h11, 0, 0, 0, 0, 0);
        step(1, 6, 8'h22, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 5, 1, 6, 0);
        checks++;
        if (rdata0 !== 8'h11 || rdata1 !== 8'h22) begin
            errors++;
            $display("[TB] FAIL dual_distinct: rdata0=%h rdata1=%h expected 11 22", rdata0, rdata1);
        end
        step(0, 0, 0, 1, 6, 1, 6, 0);
        checks++;
        if (rdata0 !== 8'h22 || rdata1 !== 8'h22) begin
            errors++;
            $display("[TB] FAIL dual_same: rdata0=%h rdata1=%h expected 22 22", rdata0, rdata1);
        end
    endtask

    task automatic test_collision();
        logic [D-1:0] want;
        want = BYPASS ? 8'hFF : 8'h00;
        step(1, 7, 8'h00, 0, 0, 0, 0, 0);
        step(1, 7, 8'hFF, 1, 7, 1, 7, 0);
        checks++;
        if (rdata0 !== want || rdata1 !== want) begin
            errors++;
            $display("[TB] FAIL collision_same_cycle: rdata0=%h rdata1=%h expected %h", rdata0, rdata1, want);
        end
        step(0, 0, 0, 1, 7, 0, 0, 0);
        checks++;
        if (rdata0 !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL collision_next_read: rdata0=%h expected ff", rdata0);
        end
    endtask

    task automatic test_clear_write();
        logic [D-1:0] want;
        step(1, 9, 8'h6B, 0, 0, 0, 0, 0);
        want = BYPASS ? 8'h00 : 8'h6B;
        step(1, 2, 8'h5A, 0, 0, 1, 9, 1);
        checks++;
        if (rdata1 !== want) begin
            errors++;
            $display("[TB] FAIL clear_read_collision: rdata1=%h expected %h", rdata1, want);
        end
        step(0, 0, 0, 1, 2, 1, 9, 0);
        checks++;
        if (rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
            errors++;
            $display("[TB] FAIL clear_beats_write: rdata0=%h rdata1=%h expected 00 00", rdata0, rdata1);
        end
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < DEPTH; i++) step(1, i, $urandom_range(255), 0, 0, 0, 0, 0);
        step(1, 250, 8'h77, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 250, 1, 255, 0);
        checks++;
        if (rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
            errors++;
            $display("[TB] FAIL oor_read: rdata0=%h rdata1=%h expected 00 00", rdata0, rdata1);
        end
        for (int i = 0; i < DEPTH; i += 2) begin
            step(0, 0, 0, 1, i, 1, i + 1, 0);
            checks++;
            if (rdata0 !== exp0 || rdata1 !== exp1) begin
                errors++;
                $display("[TB] FAIL oor_no_alias: addr %0d rdata0=%h rdata1=%h expected %h %h",
                         i, rdata0, rdata1, exp0, exp1);
            end
        end
        step(1, 199, 8'h99, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 199, 1, 200, 0);
        checks++;
        if (rdata0 !== 8'h99 || rdata1 !== 8'h00) begin
            errors++;
            $display("[TB] FAIL oor_boundary: rdata0=%h rdata1=%h expected 99 00", rdata0, rdata1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(1), $urandom_range(255), $urandom_range(255),
                 $urandom_range(1), $urandom_range(255),
                 $urandom_range(1), $urandom_range(255), $urandom_range(30) == 0);
            checks++;
            if (rdata0 !== exp0) begin
                errors++;
                $display("[TB] FAIL random_port0: cycle %0d rdata0=%h expected %h", n, rdata0, exp0);
            end
            checks++;
            if (rdata1 !== exp1) begin
                errors++;
                $display("[TB] FAIL random_port1: cycle %0d rdata1=%h expected %h", n, rdata1, exp1);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) step(1, 100 + i, 8'hC0 + i, 1, 100 + i - 1, 1, 100 + i, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 1, 100 + i, 0, 0, 0);
            checks++;
            if (rdata0 !== 8'(8'hC0 + i)) begin
                errors++;
                $display("[TB] FAIL back_to_back: addr %0d rdata0=%h expected %h", 100 + i, rdata0, 8'(8'hC0 + i));
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        clr = 1'b0;
        we = 1'b0;
        waddr = '0;
        wdata = '0;
        re0 = 1'b0;
        raddr0 = '0;
        re1 = 1'b0;
        raddr1 = '0;
        exp0 = '0;
        exp1 = '0;
        model_clear();
        #12;
        test_reset();
        test_basic();
        test_dual_port();
        test_collision();
        test_clear_write();
        test_out_of_range();
        test_back_to_back();
        test_random();
        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
